design_20_pipe: RTL and testbench

Multi-lane, multi-stage pipelined arithmetic/logic unit with valid/ready handshakes on input and output. It is the parametrised successor of the single-lane register-then-compute datapath. It carries LANES independent W-bit operand pairs per transfer, applies one of four operations, and delays the result through a DEPTH-stage stallable pipeline. It sits between an operand source and a result sink, and absorbs sink backpressure without dropping or duplicating transfers.

---
 rtl/design_20_pkg.sv | 13 +
 rtl/design_20_lane.sv | 51 +++++
 rtl/design_20_pipe.sv | 92 +++++++++
 tb/tb_design_20_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_20_pkg.sv
// rtl/design_20_pkg.sv - op encoding shared by the multi-lane ALU pipeline
package design_20_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_t;

endpackage

// File: rtl/design_20_lane.sv
// rtl/design_20_lane.sv - combinational single-lane op with carry/borrow or clamp flag
// DESIGN_20_PIPE_SAT_EN selects saturating ADD/SUB; otherwise arithmetic wraps.
module design_20_lane
  import design_20_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  op_t          i_op,
  output logic [W-1:0] o_y,
  output logic         o_flag
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  // One extra bit captures carry-out / borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_y    = '0;
    o_flag = 1'b0;
    case (i_op)
      OP_ADD: begin
`ifdef DESIGN_20_PIPE_SAT_EN
        o_y = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
`else
        o_y = w_sum[W-1:0];
`endif
        o_flag = w_sum[W];
      end
      OP_SUB: begin
`ifdef DESIGN_20_PIPE_SAT_EN
        o_y = w_diff[W] ? {W{1'b0}} : w_diff[W-1:0];
`else
        o_y = w_diff[W-1:0];
`endif
        o_flag = w_diff[W];
      end
      OP_AND: o_y = i_a & i_b;
      OP_XOR: o_y = i_a ^ i_b;
      default: begin
        o_y    = '0;
        o_flag = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/design_20_pipe.sv
// rtl/design_20_pipe.sv - LANES-wide ALU feeding a DEPTH-stage stallable valid/ready pipeline
// Saturating arithmetic is enabled by defining DESIGN_20_PIPE_SAT_EN.
module design_20_pipe
  import design_20_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_y,
  output logic [LANES-1:0]   out_flag,
  output logic               busy,
  output logic [15:0]        out_cnt
);

  logic [LANES*W-1:0] w_y0;
  logic [LANES-1:0]   w_f0;
  logic [DEPTH:0]     w_en;

  logic [DEPTH-1:0]   r_valid;
  logic [LANES*W-1:0] r_y    [DEPTH];
  logic [LANES-1:0]   r_flag [DEPTH];
  logic [15:0]        r_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    design_20_lane #(.W(W)) u_lane (
      .i_a    (in_a[i*W +: W]),
      .i_b    (in_b[i*W +: W]),
      .i_op   (op_t'(in_op)),
      .o_y    (w_y0[i*W +: W]),
      .o_flag (w_f0[i])
    );
  end

  // A stage may load when empty or when its successor loads; ripples from out_ready to in_ready.
  always_comb begin
    w_en        = '0;
    w_en[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_en[k] = !r_valid[k] || w_en[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_y[k]    <= '0;
        r_flag[k] <= '0;
      end
    end else begin
      if (w_en[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_y[0]    <= w_y0;
          r_flag[0] <= w_f0;
        end
      end
      // Data only moves with a valid transfer, so an emptied tail keeps its last result.
      for (int k = 1; k < DEPTH; k++) begin
        if (w_en[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_y[k]    <= r_y[k-1];
            r_flag[k] <= r_flag[k-1];
          end
        end
      end
      if (r_valid[DEPTH-1] && out_ready) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_en[0];
  assign out_valid = r_valid[DEPTH-1];
  assign out_y     = r_y[DEPTH-1];
  assign out_flag  = r_flag[DEPTH-1];
  assign busy      = |r_valid;
  assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_design_20_pipe.sv
// tb/tb_design_20_pipe.sv - randomized bench for design_20_pipe against a queue-based reference model
module tb_design_20_pipe;

  localparam int W     = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 2;

  typedef struct {
    logic [LANES*W-1:0] y;
    logic [LANES-1:0]   f;
  } res_t;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_y;
  logic [LANES-1:0]   out_flag;
  logic               busy;
  logic [15:0]        out_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int exp_cnt = 0;
  res_t q[$];
  bit prev_stall = 0;
  logic [LANES*W-1:0] prev_y;
  logic [LANES-1:0]   prev_f;
  bit bp_done;
  bit rand_done;
  int c0;

  design_20_pipe #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_flag  (out_flag),
    .busy      (busy),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [LANES*W-1:0] a,
                                 input logic [LANES*W-1:0] b);
    res_t r;
    longint maxv = (longint'(1) << W) - 1;
    for (int i = 0; i < LANES; i++) begin
      longint x = longint'(a[i*W +: W]);
      longint z = longint'(b[i*W +: W]);
      longint v = 0;
      bit fl = 0;
      case (op)
        2'd0: begin
          v = x + z;
          fl = (v > maxv);
`ifdef DESIGN_20_PIPE_SAT_EN
          if (fl) v = maxv;
`endif
        end
        2'd1: begin
          v = x - z;
          fl = (x < z);
`ifdef DESIGN_20_PIPE_SAT_EN
          if (fl) v = 0;
`endif
        end
        2'd2: v = x & z;
        default: v = x ^ z;
      endcase
      v = v & maxv;
      r.y[i*W +: W] = v[W-1:0];
      r.f[i] = fl;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      prev_stall = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_cnt", 32'(out_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      chk("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) || out_ready));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("out_cnt", 32'(out_cnt), 32'(exp_cnt[15:0]));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_y", 32'(out_y), 32'(prev_y));
        chk("stall_flag", 32'(out_flag), 32'(prev_f));
      end
      if (out_valid && q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        exp_cnt++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_y", 32'(out_y), 32'(e.y));
          chk("out_flag", 32'(out_flag), 32'(e.f));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_op, in_a, in_b));
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
      prev_f = out_flag;
    end
  end

  task automatic send(input logic [1:0] op, input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b);
    bit got = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_rand();
    send(2'($urandom_range(0, 3)), (LANES*W)'($urandom), (LANES*W)'($urandom));
  endtask

  task automatic send_check(input string name, input logic [1:0] op, input logic [LANES*W-1:0] a,
                            input logic [LANES*W-1:0] b, input logic [LANES*W-1:0] ey,
                            input logic [LANES-1:0] ef);
    send(op, a, b);
    repeat (DEPTH - 1) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_y"}, 32'(out_y), 32'(ey));
    chk({name, "_flag"}, 32'(out_flag), 32'(ef));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 100 && (q.size() != 0 || busy); t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = 2'd0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #1;
    chk("reset_y", 32'(out_y), 32'd0);
    chk("reset_flag", 32'(out_flag), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef DESIGN_20_PIPE_SAT_EN
    send_check("add", 2'd0, 16'hF010, 16'h2005, 16'hFF15, 2'b10);
    send_check("sub", 2'd1, 16'h1003, 16'h0105, 16'h0F00, 2'b01);
`else
    send_check("add", 2'd0, 16'hF010, 16'h2005, 16'h1015, 2'b10);
    send_check("sub", 2'd1, 16'h1003, 16'h0105, 16'h0FFE, 2'b01);
`endif
    send_check("and", 2'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 2'b00);
    send_check("xor", 2'd3, 16'hF0F0, 16'h3C3C, 16'hCCCC, 2'b00);
    drain();
    chk("directed_cnt", 32'(out_cnt), 32'd4);

    // Backpressure: five offered, only DEPTH accepted while the sink stalls.
    c0 = exp_cnt;
    out_ready = 1'b0;
    c0 = n_acc;
    bp_done = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
        bp_done = 1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_accepts", 32'(n_acc - c0), 32'(DEPTH));
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    for (int t = 0; t < 100 && !bp_done; t++) @(posedge clk);
    #1;
    chk("bp_done", 32'(bp_done), 32'd1);
    drain();
    chk("bp_cnt", 32'(out_cnt), 32'd9);

    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    chk("rand_cnt", 32'(out_cnt), 32'd1009);

    // Reset with two transfers in flight.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(out_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_check("post_rst", 2'd2, 16'hFFFF, 16'h5A5A, 16'h5A5A, 2'b00);
    drain();
    chk("post_rst_cnt", 32'(out_cnt), 32'd1);

    for (int i = 0; i < 65535; i++) send_rand();
    drain();
    chk("wrap_zero", 32'(out_cnt), 32'h0000);
    send_rand();
    drain();
    chk("wrap_one", 32'(out_cnt), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
